// File: rtl/pool_pkg.sv
// Shared constants and FSM encoding for the 2x2 max-pool engine.
package pool_pkg;

  localparam logic [31:0] IN_BASE_DEF  = 32'h6000_0000;
  localparam logic [31:0] OUT_BASE_DEF = 32'h7000_0000;

  localparam int DATA_W  = 8;
  localparam int IN_DIM  = 32;
  localparam int OUT_DIM = 16;

  localparam logic [31:0] IN_CH_STRIDE   = 32'(IN_DIM * IN_DIM);
  localparam logic [31:0] IN_ROW_STRIDE  = 32'(IN_DIM);
  localparam logic [31:0] OUT_CH_STRIDE  = 32'(OUT_DIM * OUT_DIM);
  localparam logic [31:0] OUT_ROW_STRIDE = 32'(OUT_DIM);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_CMD = 3'd1,
    RD_RSP = 3'd2,
    WR_CMD = 3'd3,
    WR_RSP = 3'd4
  } pool_state_e;

endpackage

// File: rtl/pool_icb_if.sv
// ICB command/response bus between the pool engine (master) and memory (slave).
interface pool_icb_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/pool_max4.sv
// Combinational signed max of four int8 values; with POOL_RELU_EN defined the
// result is additionally clamped at zero.
module pool_max4
  import pool_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] d,
  output logic signed [DATA_W-1:0] y
);

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] x,
                                                    input logic signed [DATA_W-1:0] z);
    return (x > z) ? x : z;
  endfunction

  logic signed [DATA_W-1:0] m;

  assign m = smax(smax(a, b), smax(c, d));

`ifdef POOL_RELU_EN
  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

  assign y = relu(m);
`else
  assign y = m;
`endif

endmodule

// File: rtl/pool_engine.sv
// 2x2/stride-2 max-pool engine: reads the conv map over ICB, writes the pooled map.
// Optional fused ReLU selected by macro POOL_RELU_EN (see pool_max4).
module pool_engine
  import pool_pkg::*;
#(
  parameter logic [31:0] IN_BASE  = IN_BASE_DEF,
  parameter logic [31:0] OUT_BASE = OUT_BASE_DEF,
  parameter int          CHANNELS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  pool_icb_if.master pool_icb
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

  pool_state_e state, state_nxt;

  logic            start_q, start_rise;
  logic [CH_W-1:0] ch, ch_nxt;
  logic [3:0]      orow, orow_nxt;
  logic [1:0]      ow, ow_nxt, k, k_nxt;
  logic            cmd_hs, rsp_hs, last_out;

  logic [31:0] rowbuf;
  logic [15:0] obuf_lo;
  logic signed [DATA_W-1:0] max_lo, max_hi;

  logic        cmd_valid_q, cmd_valid_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic        cmd_read_q, cmd_read_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;

  function automatic logic [31:0] rd_addr(input logic [CH_W-1:0] c, input logic [3:0] r,
                                          input logic [1:0] w, input logic [1:0] kk);
    logic [31:0] row, word;
    row  = {27'd0, r, kk[0]};
    word = {29'd0, w, kk[1]};
    return IN_BASE + 32'(c) * IN_CH_STRIDE + row * IN_ROW_STRIDE + (word << 2);
  endfunction

  function automatic logic [31:0] wr_addr(input logic [CH_W-1:0] c, input logic [3:0] r,
                                          input logic [1:0] w);
    return OUT_BASE + 32'(c) * OUT_CH_STRIDE + 32'(r) * OUT_ROW_STRIDE + {28'd0, w, 2'b00};
  endfunction

  assign start_rise = start & ~start_q;
  assign cmd_hs     = cmd_valid_q & pool_icb.cmd_ready;
  assign rsp_hs     = pool_icb.rsp_valid & ((state == RD_RSP) | (state == WR_RSP));
  assign last_out   = (ch == CH_LAST) && (orow == 4'd15) && (ow == 2'd3);

  // Columns 0,1 and 2,3 of the row pair reduce in parallel.
  pool_max4 u_max_lo (
    .a(rowbuf[7:0]),            .b(rowbuf[15:8]),
    .c(pool_icb.rsp_rdata[7:0]), .d(pool_icb.rsp_rdata[15:8]),
    .y(max_lo)
  );

  pool_max4 u_max_hi (
    .a(rowbuf[23:16]),            .b(rowbuf[31:24]),
    .c(pool_icb.rsp_rdata[23:16]), .d(pool_icb.rsp_rdata[31:24]),
    .y(max_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_rise) state_nxt = RD_CMD;
      RD_CMD:  if (cmd_hs)     state_nxt = RD_RSP;
      RD_RSP:  if (rsp_hs)     state_nxt = (k == 2'd3) ? WR_CMD : RD_CMD;
      WR_CMD:  if (cmd_hs)     state_nxt = WR_RSP;
      WR_RSP:  if (rsp_hs)     state_nxt = last_out ? IDLE : RD_CMD;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Loop nest k -> ow -> orow -> ch; everything wraps to 0 after the last write.
  always_comb begin
    k_nxt    = k;
    ow_nxt   = ow;
    orow_nxt = orow;
    ch_nxt   = ch;
    if (state == RD_RSP && rsp_hs) k_nxt = k + 2'd1;
    if (state == WR_RSP && rsp_hs) begin
      ow_nxt = ow + 2'd1;
      if (ow == 2'd3) begin
        orow_nxt = orow + 4'd1;
        if (orow == 4'd15) ch_nxt = (ch == CH_LAST) ? '0 : ch + CH_W'(1);
      end
    end
  end

  // Command fields are loaded on entry to a command state and held until accepted.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_read_d  = cmd_read_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    if (cmd_hs) cmd_valid_d = 1'b0;
    if (state_nxt == RD_CMD && state != RD_CMD) begin
      cmd_valid_d = 1'b1;
      cmd_addr_d  = rd_addr(ch_nxt, orow_nxt, ow_nxt, k_nxt);
      cmd_read_d  = 1'b1;
      wdata_d     = '0;
      wmask_d     = 4'h0;
    end
    if (state_nxt == WR_CMD && state != WR_CMD) begin
      cmd_valid_d = 1'b1;
      cmd_addr_d  = wr_addr(ch_nxt, orow_nxt, ow_nxt);
      cmd_read_d  = 1'b0;
      wdata_d     = {max_hi, max_lo, obuf_lo};
      wmask_d     = 4'hF;
    end
    if (state == IDLE && start_rise) begin
      busy_d = 1'b1;
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (rsp_hs && pool_icb.rsp_err) err_d = 1'b1;
    if (state == WR_RSP && rsp_hs && last_out) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= 1'b0;
      k           <= '0;
      ow          <= '0;
      orow        <= '0;
      ch          <= '0;
      rowbuf      <= '0;
      obuf_lo     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_read_q  <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      start_q     <= start;
      k           <= k_nxt;
      ow          <= ow_nxt;
      orow        <= orow_nxt;
      ch          <= ch_nxt;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_read_q  <= cmd_read_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      // Even k holds the top row; k=1 finishes bytes 0,1, k=3 goes straight to wdata.
      if (state == RD_RSP && rsp_hs) begin
        if (!k[0])      rowbuf  <= pool_icb.rsp_rdata;
        else if (!k[1]) obuf_lo <= {max_hi, max_lo};
      end
    end
  end

  assign pool_icb.cmd_valid = cmd_valid_q;
  assign pool_icb.cmd_addr  = cmd_addr_q;
  assign pool_icb.cmd_read  = cmd_read_q;
  assign pool_icb.cmd_wdata = wdata_q;
  assign pool_icb.cmd_wmask = wmask_q;
  assign pool_icb.rsp_ready = 1'b1;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_pool_engine.sv
// Bench for pool_engine: memory-model ICB slave plus a scoreboard of the full
// expected command sequence of each run.
module tb_pool_engine;

  localparam int CH       = 16;
  localparam int RUN_TXNS = CH * 16 * 4 * 5;
  localparam logic [31:0] IN_BASE  = 32'h6000_0000;
  localparam logic [31:0] OUT_BASE = 32'h7000_0000;
`ifdef POOL_RELU_EN
  localparam logic [7:0] BLK_EXP = 8'h00;
`else
  localparam logic [7:0] BLK_EXP = 8'hFF;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [31:0] wdata;
  } txn_t;

  logic clk, rst_n, start, busy, done, err;
  pool_icb_if icb ();

  pool_engine #(.IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .err(err), .pool_icb(icb)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [4096];
  txn_t        exp_q[$];
  int          txn_cnt, rd_cnt, err_rd;
  bit          stall_en, first_wr_seen;
  logic [31:0] first_wr_addr, first_wr_data, first_rd_addr, blk_wdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pool_byte(input int c, input int orow, input int ow, input int j);
    logic signed [7:0] m, b;
    logic [31:0] wd;
    int w, col;
    w   = 2 * ow + j / 2;
    col = 2 * (j % 2);
    m   = 8'sh80;
    for (int r = 0; r < 2; r++) begin
      wd = mem[c * 256 + (2 * orow + r) * 8 + w];
      for (int x = 0; x < 2; x++) begin
        b = wd[8 * (col + x) +: 8];
        if (b > m) m = b;
      end
    end
`ifdef POOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  task automatic build_exp();
    txn_t t;
    exp_q.delete();
    for (int c = 0; c < CH; c++)
      for (int orow = 0; orow < 16; orow++)
        for (int ow = 0; ow < 4; ow++) begin
          for (int k = 0; k < 4; k++) begin
            t.addr  = IN_BASE + 32'(c * 1024 + (2 * orow + k % 2) * 32 + (2 * ow + k / 2) * 4);
            t.rd    = 1'b1;
            t.wdata = '0;
            exp_q.push_back(t);
          end
          t.addr  = OUT_BASE + 32'(c * 256 + orow * 16 + ow * 4);
          t.rd    = 1'b0;
          t.wdata = {pool_byte(c, orow, ow, 3), pool_byte(c, orow, ow, 2),
                     pool_byte(c, orow, ow, 1), pool_byte(c, orow, ow, 0)};
          exp_q.push_back(t);
        end
  endtask

  // ICB slave: drives at negedge, responds the cycle after each accepted command.
  initial begin
    bit          hs_prev, prev_rd, hold_seen;
    logic [31:0] prev_addr, h_addr, h_wdata, off;
    logic        h_read;
    int          stall_left;
    txn_t        e;
    icb.cmd_ready = 1'b0;
    icb.rsp_valid = 1'b0;
    icb.rsp_rdata = '0;
    icb.rsp_err   = 1'b0;
    hs_prev = 0; prev_rd = 0; hold_seen = 0; stall_left = 0;
    prev_addr = '0; h_addr = '0; h_wdata = '0; h_read = 1'b0;
    forever begin
      @(negedge clk);
      icb.rsp_valid = 1'b0;
      icb.rsp_err   = 1'b0;
      if (!rst_n) begin
        icb.cmd_ready = 1'b0;
        hs_prev = 0; hold_seen = 0; stall_left = 0;
      end else begin
        if (hs_prev) begin
          icb.rsp_valid = 1'b1;
          if (prev_rd) begin
            off = prev_addr - IN_BASE;
            icb.rsp_rdata = (off < 32'd16384) ? mem[off[13:2]] : 32'hDEAD_BEEF;
            icb.rsp_err   = (rd_cnt == err_rd);
          end else begin
            icb.rsp_rdata = $urandom;
          end
          hs_prev = 0;
        end
        if (icb.cmd_valid) begin
          if (!hold_seen) begin
            h_addr = icb.cmd_addr; h_read = icb.cmd_read; h_wdata = icb.cmd_wdata;
            hold_seen = 1;
          end else begin
            check("hold_addr", icb.cmd_addr, h_addr);
            check("hold_read", {31'd0, icb.cmd_read}, {31'd0, h_read});
            check("hold_wdata", icb.cmd_wdata, h_wdata);
          end
          if (stall_left > 0) begin
            stall_left--;
            icb.cmd_ready = 1'b0;
          end else begin
            icb.cmd_ready = 1'b1;
            hold_seen = 0;
            hs_prev   = 1;
            prev_rd   = icb.cmd_read;
            prev_addr = icb.cmd_addr;
            txn_cnt++;
            if (icb.cmd_read) begin
              if (rd_cnt == 0) first_rd_addr = icb.cmd_addr;
              rd_cnt++;
            end else begin
              if (!first_wr_seen) begin
                first_wr_addr = icb.cmd_addr;
                first_wr_data = icb.cmd_wdata;
                first_wr_seen = 1;
              end
              if (icb.cmd_addr == OUT_BASE + 32'd256) blk_wdata = icb.cmd_wdata;
            end
            if (exp_q.size() == 0) begin
              check("sb_size", 32'(exp_q.size()), 32'd1);
            end else begin
              e = exp_q.pop_front();
              check("addr", icb.cmd_addr, e.addr);
              check("read", {31'd0, icb.cmd_read}, {31'd0, e.rd});
              check("wdata", icb.cmd_wdata, e.wdata);
              check("wmask", {28'd0, icb.cmd_wmask}, e.rd ? 32'h0 : 32'hF);
            end
            stall_left = stall_en ? int'($urandom_range(5, 0)) : 0;
          end
        end else begin
          icb.cmd_ready = 1'b0;
        end
      end
    end
  end

  task automatic start_run(input bit st, input int ea);
    stall_en = st; err_rd = ea; txn_cnt = 0; rd_cnt = 0; first_wr_seen = 0;
    build_exp();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("busy_on_start", {31'd0, busy}, 32'd1);
    check("done_on_start", {31'd0, done}, 32'd0);
    check("err_on_start", {31'd0, err}, 32'd0);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    check("done", {31'd0, done}, 32'd1);
    check("busy_end", {31'd0, busy}, 32'd0);
    check("txn_total", 32'(txn_cnt), 32'(RUN_TXNS));
    check("sb_left", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);
    check("txn_after_done", 32'(txn_cnt), 32'(RUN_TXNS));
    check("valid_after_done", {31'd0, icb.cmd_valid}, 32'd0);
  endtask

  initial begin
    int cyc, saved;
    rst_n = 1'b0; start = 1'b0;
    txn_cnt = 0; rd_cnt = 0; err_rd = -1; stall_en = 0; first_wr_seen = 0;
    first_wr_addr = '0; first_wr_data = '0; first_rd_addr = '0; blk_wdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[0] = 32'h0403_0201;
    mem[1] = 32'h0807_0605;
    mem[8] = 32'h0C0B_0A09;
    mem[9] = 32'h100F_0E0D;
    mem[256][15:0] = 16'hFDFB;
    mem[264][15:0] = 16'hFFF8;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_valid", {31'd0, icb.cmd_valid}, 32'd0);
    check("rst_read", {31'd0, icb.cmd_read}, 32'd0);
    check("rst_addr", icb.cmd_addr, 32'd0);
    check("rst_wdata", icb.cmd_wdata, 32'd0);
    check("rst_wmask", {28'd0, icb.cmd_wmask}, 32'd0);
    rst_n = 1'b1;

    // Zero-wait run with a start pulse injected mid-run.
    start_run(0, -1);
    repeat (200) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("first_wr_addr", first_wr_addr, 32'h7000_0000);
    check("first_wr_data", first_wr_data, 32'h100E_0C0A);
    check("neg_block", {24'd0, blk_wdata[7:0]}, {24'd0, BLK_EXP});

    // Stalled run with an error response on the 100th read.
    start_run(1, 100);
    wait_done();
    check("err_sticky", {31'd0, err}, 32'd1);

    // Restart clears err; reset abandons the run at transaction 2000.
    start_run(0, -1);
    cyc = 0;
    while (txn_cnt < 2000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_2000", {31'd0, txn_cnt >= 2000}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", {31'd0, icb.cmd_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_err", {31'd0, err}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saved = txn_cnt;
    repeat (30) @(negedge clk);
    check("quiet_after_rst", 32'(txn_cnt), 32'(saved));
    check("quiet_valid", {31'd0, icb.cmd_valid}, 32'd0);

    start_run(0, -1);
    wait_done();
    check("restart_rd_addr", first_rd_addr, 32'h6000_0000);
    check("err_clear_end", {31'd0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
